// File: rtl/decode_hazard_unit_pkg.sv
// Shared decode-stage pipeline definitions: hazard FSM states, scoreboard
// entry layout, drain depth and the NOP control word used by the ID/EX bubble mux.
package decode_hazard_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] dst;
    } sb_entry_t;

    // Cycles spent in DRAIN after entry before HALTED: lets the halting
    // instruction walk through EX, MEM and WB.
    localparam logic [1:0] DRAIN_DEPTH = 2'd2;

    typedef struct packed {
        logic reg_wr;
        logic mem_wr;
        logic mem_rd;
        logic dump;
        logic err;
    } idex_ctrl_t;

    localparam idex_ctrl_t IDEX_NOP_CTRL = '0;

    function automatic logic entry_hit(input sb_entry_t e, input logic [2:0] r);
        return e.valid && (e.dst == r);
    endfunction

endpackage

// File: rtl/decode_hazard_unit_sb_match.sv
// Compares one decode source register against the in-flight scoreboard entries.
module sb_match
    import decode_hazard_unit_pkg::*;
#(
    parameter bit CHECK_WB = 1'b0
) (
    input  logic [2:0] i_src_num,
    input  logic       i_src_used,
    input  sb_entry_t  i_ex,
    input  sb_entry_t  i_mem,
    input  sb_entry_t  i_wb,
    output logic       o_hit
);

    always_comb begin
        o_hit = i_src_used &&
                (entry_hit(i_ex, i_src_num) ||
                 entry_hit(i_mem, i_src_num) ||
                 (CHECK_WB && entry_hit(i_wb, i_src_num)));
    end

endmodule

// File: rtl/decode_hazard_unit.sv
// Decode-stage RAW hazard detection, halt/error drain sequencing and
// PC / IF/ID / ID/EX pipeline control for a non-forwarding pipeline.
module decode_hazard_unit
    import decode_hazard_unit_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_rs_num,
    input  logic        id_rs_used,
    input  logic [2:0]  id_rt_num,
    input  logic        id_rt_used,
    input  logic        id_wr_en,
    input  logic [2:0]  id_dst_num,
    input  logic        id_halt,
    input  logic        id_err,
    input  logic        ex_redirect,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_bubble,
    output logic        halted,
    output logic        err_sticky,
    output logic [15:0] stall_cnt
);

    sb_entry_t   r_sb_ex;
    sb_entry_t   r_sb_mem;
    sb_entry_t   r_sb_wb;
    hz_state_t   r_state;
    hz_state_t   w_state_nxt;
    logic [1:0]  r_drain_cnt;
    logic [1:0]  w_drain_cnt_nxt;
    logic        r_err_sticky;
    logic [15:0] r_stall_cnt;

    logic        w_rs_hit;
    logic        w_rt_hit;
    logic        w_raw;
    logic        w_run;
    logic        w_accept;
    logic        w_stall;

    sb_match #(.CHECK_WB(!WB_BYPASS)) u_rs_match (
        .i_src_num  (id_rs_num),
        .i_src_used (id_rs_used),
        .i_ex       (r_sb_ex),
        .i_mem      (r_sb_mem),
        .i_wb       (r_sb_wb),
        .o_hit      (w_rs_hit)
    );

    sb_match #(.CHECK_WB(!WB_BYPASS)) u_rt_match (
        .i_src_num  (id_rt_num),
        .i_src_used (id_rt_used),
        .i_ex       (r_sb_ex),
        .i_mem      (r_sb_mem),
        .i_wb       (r_sb_wb),
        .o_hit      (w_rt_hit)
    );

    always_comb begin
        w_raw    = id_valid && (w_rs_hit || w_rt_hit);
        w_run    = (r_state == ST_RUN);
        w_accept = id_valid && !w_raw && !ex_redirect && w_run;
        // A redirect squashes the decode slot, so its hazard is not a stall.
        w_stall  = w_raw && !ex_redirect && w_run;
    end

    always_comb begin
        pc_en           = 1'b1;
        ifid_en         = 1'b1;
        ifid_flush      = 1'b0;
        idex_en         = 1'b1;
        idex_bubble     = 1'b0;
        halted          = 1'b0;
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            ST_RUN: begin
                if (ex_redirect) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (w_raw) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (w_accept && (id_halt || id_err)) begin
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = DRAIN_DEPTH;
                end
            end
            ST_DRAIN: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                if (r_drain_cnt == 2'd0) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - 2'd1;
                end
            end
            ST_HALTED: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                idex_bubble = 1'b1;
                halted      = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sb_ex      <= '0;
            r_sb_mem     <= '0;
            r_sb_wb      <= '0;
            r_state      <= ST_RUN;
            r_drain_cnt  <= '0;
            r_err_sticky <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            r_sb_wb       <= r_sb_mem;
            r_sb_mem      <= r_sb_ex;
            r_sb_ex.valid <= id_valid && id_wr_en && w_accept;
            r_sb_ex.dst   <= id_dst_num;
            r_state       <= w_state_nxt;
            r_drain_cnt   <= w_drain_cnt_nxt;
            if (w_accept && id_err) begin
                r_err_sticky <= 1'b1;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign err_sticky = r_err_sticky;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Bench for decode_hazard_unit: one instance with WB bypass, one without,
// driven by shared stimulus and checked against a history-based reference.
`timescale 1ns/1ps
module tb_decode_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_rs_num;
    logic       id_rs_used;
    logic [2:0] id_rt_num;
    logic       id_rt_used;
    logic       id_wr_en;
    logic [2:0] id_dst_num;
    logic       id_halt;
    logic       id_err;
    logic       ex_redirect;

    logic pc_en_b1, ifid_en_b1, ifid_flush_b1, idex_en_b1, idex_bubble_b1, halted_b1, err_sticky_b1;
    logic pc_en_b0, ifid_en_b0, ifid_flush_b0, idex_en_b0, idex_bubble_b0, halted_b0, err_sticky_b0;
    logic [15:0] stall_cnt_b1, stall_cnt_b0;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    decode_hazard_unit #(.WB_BYPASS(1'b1)) u_b1 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_num(id_rs_num), .id_rs_used(id_rs_used),
        .id_rt_num(id_rt_num), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_dst_num(id_dst_num),
        .id_halt(id_halt), .id_err(id_err), .ex_redirect(ex_redirect),
        .pc_en(pc_en_b1), .ifid_en(ifid_en_b1), .ifid_flush(ifid_flush_b1),
        .idex_en(idex_en_b1), .idex_bubble(idex_bubble_b1), .halted(halted_b1),
        .err_sticky(err_sticky_b1), .stall_cnt(stall_cnt_b1)
    );

    decode_hazard_unit #(.WB_BYPASS(1'b0)) u_b0 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_num(id_rs_num), .id_rs_used(id_rs_used),
        .id_rt_num(id_rt_num), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_dst_num(id_dst_num),
        .id_halt(id_halt), .id_err(id_err), .ex_redirect(ex_redirect),
        .pc_en(pc_en_b0), .ifid_en(ifid_en_b0), .ifid_flush(ifid_flush_b0),
        .idex_en(idex_en_b0), .idex_bubble(idex_bubble_b0), .halted(halted_b0),
        .err_sticky(err_sticky_b0), .stall_cnt(stall_cnt_b0)
    );

    // Control bits packed as {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, halted, err_sticky}
    logic [6:0]  act_ctl [2];
    logic [15:0] act_cnt [2];
    always_comb begin
        act_ctl[1] = {pc_en_b1, ifid_en_b1, ifid_flush_b1, idex_en_b1, idex_bubble_b1, halted_b1, err_sticky_b1};
        act_ctl[0] = {pc_en_b0, ifid_en_b0, ifid_flush_b0, idex_en_b0, idex_bubble_b0, halted_b0, err_sticky_b0};
        act_cnt[1] = stall_cnt_b1;
        act_cnt[0] = stall_cnt_b0;
    end

    // Reference: index 1 = WB bypass, index 0 = no bypass.
    // hist[b][k] is the write of the instruction accepted k+1 edges ago.
    bit         m_hv   [2][3];
    logic [2:0] m_hd   [2][3];
    int         m_age  [2];   // edges since halt/err accepted, 0 = still running
    bit         m_err  [2];
    int         m_stall[2];

    task automatic m_reset();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 3; k++) begin
                m_hv[b][k] = 1'b0;
                m_hd[b][k] = 3'd0;
            end
            m_age[b]   = 0;
            m_err[b]   = 1'b0;
            m_stall[b] = 0;
        end
    endtask

    function automatic bit m_inflight(int b, logic [2:0] r);
        int depth = (b == 1) ? 2 : 3;
        for (int k = 0; k < depth; k++)
            if (m_hv[b][k] && m_hd[b][k] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_raw(int b);
        return id_valid && ((id_rs_used && m_inflight(b, id_rs_num)) ||
                            (id_rt_used && m_inflight(b, id_rt_num)));
    endfunction

    function automatic logic [6:0] m_ctl(int b);
        logic e = m_err[b];
        if (m_age[b] >= 4)   return {6'b000011, e};
        if (m_age[b] > 0)    return {6'b000110, e};
        if (ex_redirect)     return {6'b111110, e};
        if (m_raw(b))        return {6'b000110, e};
        return {6'b110100, e};
    endfunction

    task automatic m_clock();
        for (int b = 0; b < 2; b++) begin
            bit running = (m_age[b] == 0);
            bit raw     = m_raw(b);
            bit acc     = running && id_valid && !raw && !ex_redirect;
            if (running && raw && !ex_redirect && m_stall[b] < 65535) m_stall[b]++;
            for (int k = 2; k > 0; k--) begin
                m_hv[b][k] = m_hv[b][k-1];
                m_hd[b][k] = m_hd[b][k-1];
            end
            m_hv[b][0] = acc && id_wr_en;
            m_hd[b][0] = id_dst_num;
            if (m_age[b] > 0 && m_age[b] < 100) m_age[b]++;
            if (acc && (id_halt || id_err)) m_age[b] = 1;
            if (acc && id_err) m_err[b] = 1'b1;
        end
    endtask

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(string tag);
        for (int b = 0; b < 2; b++) begin
            check($sformatf("%s_ctl_b%0d", tag, b), {9'd0, act_ctl[b]}, {9'd0, m_ctl(b)});
            check($sformatf("%s_cnt_b%0d", tag, b), act_cnt[b], m_stall[b][15:0]);
        end
    endtask

    task automatic set_in(logic v, logic [2:0] rs, logic rsu, logic [2:0] rt, logic rtu,
                          logic we, logic [2:0] dst, logic halt, logic err, logic redir);
        id_valid = v;   id_rs_num = rs;  id_rs_used = rsu;
        id_rt_num = rt; id_rt_used = rtu; id_wr_en = we;
        id_dst_num = dst; id_halt = halt; id_err = err; ex_redirect = redir;
    endtask

    task automatic idle();
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step(string tag);
        #1;
        check_model(tag);
        @(posedge clk);
        m_clock();
        #1;
    endtask

    // Asserts reset between edges and checks outputs before any clock edge.
    task automatic do_reset(string tag);
        idle();
        rst = 1'b0;
        #1;
        for (int b = 0; b < 2; b++) begin
            check($sformatf("%s_rst_ctl_b%0d", tag, b), {9'd0, act_ctl[b]}, 16'h0068);
            check($sformatf("%s_rst_cnt_b%0d", tag, b), act_cnt[b], 16'h0000);
        end
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic v; logic [2:0] rs; logic rsu; logic [2:0] rt; logic rtu;
        logic we; logic [2:0] dst; logic redir;
        logic [2:0] e1; logic [15:0] c1;
        logic [2:0] e0; logic [15:0] c0;
    } vec_t;

    function automatic vec_t mk(logic v, logic [2:0] rs, logic rsu, logic [2:0] rt, logic rtu,
                                logic we, logic [2:0] dst, logic redir,
                                logic [2:0] e1, int c1, logic [2:0] e0, int c0);
        vec_t t;
        t.v = v; t.rs = rs; t.rsu = rsu; t.rt = rt; t.rtu = rtu;
        t.we = we; t.dst = dst; t.redir = redir;
        t.e1 = e1; t.c1 = c1[15:0]; t.e0 = e0; t.c0 = c0[15:0];
        return t;
    endfunction

    initial begin
        vec_t tbl[$];
        // Expected {pc_en, idex_bubble, ifid_flush}
        logic [2:0] ACC = 3'b100;
        logic [2:0] STL = 3'b010;
        logic [2:0] RDR = 3'b111;
        int seg_cycles;

        rst = 1'b1;
        idle();
        m_reset();
        #3;
        do_reset("init");

        tbl.push_back(mk(1,0,0,0,0,1,3,0, ACC,0, ACC,0));  // write r3
        tbl.push_back(mk(1,3,1,0,0,0,0,0, STL,0, STL,0));  // read r3
        tbl.push_back(mk(1,3,1,0,0,0,0,0, STL,1, STL,1));
        tbl.push_back(mk(1,3,1,0,0,0,0,0, ACC,2, STL,2));
        tbl.push_back(mk(1,3,1,0,0,0,0,0, ACC,2, ACC,3));
        tbl.push_back(mk(1,0,0,0,0,1,7,0, ACC,2, ACC,3));  // write r7
        tbl.push_back(mk(1,1,1,2,1,0,0,0, ACC,2, ACC,3));  // independent r1/r2
        tbl.push_back(mk(1,0,0,0,0,1,0,0, ACC,2, ACC,3));  // write r0
        tbl.push_back(mk(1,5,0,0,1,0,0,0, STL,2, STL,3));  // rt=r0, rs unused
        tbl.push_back(mk(1,5,0,0,1,0,0,0, STL,3, STL,4));
        tbl.push_back(mk(1,5,0,0,1,0,0,0, ACC,4, STL,5));
        tbl.push_back(mk(1,5,0,0,1,0,0,0, ACC,4, ACC,6));
        tbl.push_back(mk(1,0,0,0,0,1,2,0, ACC,4, ACC,6));  // write r2
        tbl.push_back(mk(0,0,0,0,0,0,0,0, ACC,4, ACC,6));  // empty slot
        tbl.push_back(mk(1,2,1,0,0,0,0,0, STL,4, STL,6));  // two-ahead dependency
        tbl.push_back(mk(1,2,1,0,0,0,0,0, ACC,5, STL,7));
        tbl.push_back(mk(1,2,1,0,0,0,0,0, ACC,5, ACC,8));
        tbl.push_back(mk(1,0,0,0,0,1,5,0, ACC,5, ACC,8));  // write r5
        tbl.push_back(mk(1,5,1,0,0,1,6,1, RDR,5, RDR,8));  // redirect over raw, squashed write r6
        tbl.push_back(mk(1,6,1,0,0,0,0,0, ACC,5, ACC,8));  // r6 never entered
        tbl.push_back(mk(1,0,0,5,1,0,0,0, ACC,5, STL,8));  // r5 sits in WB
        tbl.push_back(mk(1,0,0,5,1,0,0,0, ACC,5, ACC,9));

        foreach (tbl[i]) begin
            set_in(tbl[i].v, tbl[i].rs, tbl[i].rsu, tbl[i].rt, tbl[i].rtu,
                   tbl[i].we, tbl[i].dst, 1'b0, 1'b0, tbl[i].redir);
            #1;
            check($sformatf("vec%0d_ctl_b1", i), {13'd0, pc_en_b1, idex_bubble_b1, ifid_flush_b1}, {13'd0, tbl[i].e1});
            check($sformatf("vec%0d_cnt_b1", i), stall_cnt_b1, tbl[i].c1);
            check($sformatf("vec%0d_ctl_b0", i), {13'd0, pc_en_b0, idex_bubble_b0, ifid_flush_b0}, {13'd0, tbl[i].e0});
            check($sformatf("vec%0d_cnt_b0", i), stall_cnt_b0, tbl[i].c0);
            @(posedge clk);
            m_clock();
            #1;
        end
        idle();
        step("post_tbl");

        // HALT accepted, then redirects and valid decode during drain must change nothing.
        do_reset("halt");
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        step("halt_acc");
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
            #1;
            check($sformatf("halt_seq%0d_b1", i), {12'd0, halted_b1, idex_en_b1, pc_en_b1, ifid_flush_b1},
                  (i < 3) ? 16'h0004 : 16'h0008);
            check($sformatf("halt_seq%0d_b0", i), {12'd0, halted_b0, idex_en_b0, pc_en_b0, ifid_flush_b0},
                  (i < 3) ? 16'h0004 : 16'h0008);
            check_model("halt_drain");
            @(posedge clk);
            m_clock();
            #1;
        end

        // Halt and redirect together: halt squashed, pipeline keeps running.
        do_reset("halt_redir");
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
        step("halt_redir");
        idle();
        for (int i = 0; i < 5; i++) step("halt_redir_after");
        check("halt_redir_halted", {14'd0, halted_b1, halted_b0}, 16'h0000);

        // Stall then error: sticky error, drain, reset in the middle of DRAIN.
        do_reset("err");
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
        step("err_w4");
        set_in(1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("err_r4");
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        step("err_acc");
        idle();
        #1;
        check("err_sticky", {14'd0, err_sticky_b1, err_sticky_b0}, 16'h0003);
        step("err_drain");
        do_reset("err_mid_drain");

        // Saturation: start the counter just below full and keep stalling.
        idle();
        u_b1.r_stall_cnt = 16'hFFF0;
        u_b0.r_stall_cnt = 16'hFFF0;
        m_stall[0] = 32'h0000FFF0;
        m_stall[1] = 32'h0000FFF0;
        set_in(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step("sat");
        check("sat_b1", stall_cnt_b1, 16'hFFFF);
        check("sat_b0", stall_cnt_b0, 16'hFFFF);

        // Randomized segments against the reference, reset between segments.
        for (int seg = 0; seg < 6; seg++) begin
            do_reset("rnd");
            seg_cycles = 150;
            for (int c = 0; c < seg_cycles; c++) begin
                set_in($urandom_range(0, 3) != 0,
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                       $urandom_range(0, 7) == 0);
                step("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
